// File: rtl/pipe_skid_stage_pkg.sv
// Shared types and constants for the elastic multi-lane pipeline stage.
// Default lane geometry, group struct and the occupancy encoding exposed on occ.
package pipe_skid_stage_pkg;

    localparam int unsigned LANES_DEF = 2;
    localparam int unsigned W_DEF     = 64;

    typedef logic [W_DEF-1:0] lane_payload_t;

    typedef struct packed {
        logic [LANES_DEF-1:0]       v;
        logic [LANES_DEF*W_DEF-1:0] d;
    } stage_grp_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // Encoded so the state register doubles as the occ output.
    typedef enum logic [1:0] {
        StEmpty = OCC_EMPTY,
        StOne   = OCC_ONE,
        StTwo   = OCC_TWO
    } occ_state_e;

    function automatic logic grp_any_valid(input logic [LANES_DEF-1:0] v);
        return |v;
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Multi-lane valid/ready pipeline register with a one-entry skid buffer,
// registered in_ready, global flush and per-lane kill of the held main entry.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned W     = W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [LANES-1:0]   kill_mask,
    input  logic [LANES-1:0]   in_valid,
    input  logic [LANES*W-1:0] in_data,
    output logic               in_ready,
    output logic [LANES-1:0]   out_valid,
    output logic [LANES*W-1:0] out_data,
    input  logic               out_ready,
    output logic [1:0]         occ
);

    typedef struct packed {
        logic [LANES-1:0]   v;
        logic [LANES*W-1:0] d;
    } grp_t;

    grp_t       m_q, m_d;
    grp_t       s_q, s_d;
    grp_t       in_grp;
    occ_state_e st_q, st_d;
    logic       in_ready_q, in_ready_d;
    logic       in_fire, out_fire;
    logic [LANES-1:0] kept_v;

    always_comb begin
        in_grp.v = in_valid;
        in_grp.d = in_data;
        in_fire  = in_ready_q & (|in_valid);
        out_fire = out_ready & (|m_q.v);
        kept_v   = m_q.v & ~kill_mask;

        m_d  = m_q;
        s_d  = s_q;
        st_d = st_q;

        if (flush) begin
            m_d  = '0;
            s_d  = '0;
            st_d = StEmpty;
        end else begin
            unique case (st_q)
                StEmpty: begin
                    if (in_fire) begin
                        m_d  = in_grp;
                        st_d = StOne;
                    end
                end
                StOne: begin
                    if (out_fire || kept_v == '0) begin
                        // M leaves (consumed or fully killed); a new group refills it directly.
                        if (in_fire) begin
                            m_d = in_grp;
                        end else begin
                            m_d.v = '0;
                            st_d  = StEmpty;
                        end
                    end else begin
                        m_d.v = kept_v;
                        if (in_fire) begin
                            s_d  = in_grp;
                            st_d = StTwo;
                        end
                    end
                end
                StTwo: begin
                    if (out_fire || kept_v == '0) begin
                        m_d  = s_q;
                        s_d  = '0;
                        st_d = StOne;
                    end else begin
                        m_d.v = kept_v;
                    end
                end
                default: begin
                    m_d  = '0;
                    s_d  = '0;
                    st_d = StEmpty;
                end
            endcase
        end

        in_ready_d = (st_d != StTwo);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q        <= '0;
            s_q        <= '0;
            st_q       <= StEmpty;
            in_ready_q <= 1'b1;
        end else begin
            m_q        <= m_d;
            s_q        <= s_d;
            st_q       <= st_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = m_q.v;
    assign out_data  = m_q.d;
    assign occ       = st_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: groups pushed to a scoreboard when accepted,
// popped and compared whenever the stage hands one downstream.
module tb_pipe_skid_stage;

    localparam int unsigned LANES = 2;
    localparam int unsigned W     = 16;

    typedef struct {
        logic [LANES-1:0]   v;
        logic [LANES*W-1:0] d;
    } grp_t;

    logic               clk;
    logic               rst;
    logic               flush;
    logic [LANES-1:0]   kill_mask;
    logic [LANES-1:0]   in_valid;
    logic [LANES*W-1:0] in_data;
    logic               in_ready;
    logic [LANES-1:0]   out_valid;
    logic [LANES*W-1:0] out_data;
    logic               out_ready;
    logic [1:0]         occ;

    grp_t sb[$];
    int   n_pass;
    int   n_total;

    pipe_skid_stage #(
        .LANES(LANES),
        .W    (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .kill_mask(kill_mask),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .occ      (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [LANES*W-1:0] msk(input logic [LANES-1:0] v,
                                              input logic [LANES*W-1:0] d);
        logic [LANES*W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) if (v[i]) r[i*W +: W] = d[i*W +: W];
        return r;
    endfunction

    function automatic logic [LANES*W-1:0] mk(input logic [W-1:0] l1, input logic [W-1:0] l0);
        return {l1, l0};
    endfunction

    task automatic drive(input logic [LANES-1:0] v, input logic [LANES*W-1:0] d,
                         input bit push);
        grp_t g;
        in_valid = v;
        in_data  = d;
        if (push) begin
            g.v = v;
            g.d = d;
            sb.push_back(g);
        end
    endtask

    // Compare any group handed downstream at the coming edge, then advance one cycle.
    task automatic tick();
        grp_t g;
        if (out_ready === 1'b1 && (|out_valid) === 1'b1) begin
            chk("sb_avail", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                g = sb.pop_front();
                chk("pop_valid", 64'(out_valid), 64'(g.v));
                chk("pop_data", 64'(msk(out_valid, out_data)), 64'(msk(g.v, g.d)));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        grp_t g;
        logic [LANES*W-1:0] a, b, x, y;
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        kill_mask = '0;
        out_ready = 1'b1;
        drive(2'b11, mk(16'hdead, 16'hbeef), 1'b0);

        // Reset
        tick();
        tick();
        rst = 1'b0;
        drive(2'b00, '0, 1'b0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("idle_occ", 64'(occ), 64'd0);

        // Streaming
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, mk(16'h0110 + 16'(i), 16'h0010 + 16'(i)), 1'b1);
            chk("stream_in_ready", 64'(in_ready), 64'd1);
            tick();
            chk("stream_lat_valid", 64'(out_valid), 64'd3);
            chk("stream_lat_data", 64'(out_data), 64'(mk(16'h0110 + 16'(i), 16'h0010 + 16'(i))));
        end
        drive(2'b00, '0, 1'b0);
        tick();
        chk("stream_drain_occ", 64'(occ), 64'd0);

        // Skid
        a = mk(16'haaa1, 16'haaa0);
        b = mk(16'hbbb1, 16'hbbb0);
        drive(2'b11, a, 1'b1);
        tick();
        out_ready = 1'b0;
        drive(2'b10, b, 1'b1);
        tick();
        drive(2'b11, mk(16'hcccc, 16'hcccc), 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("skid_occ", 64'(occ), 64'd2);
            chk("skid_in_ready", 64'(in_ready), 64'd0);
            chk("skid_hold_data", 64'(out_data), 64'(a));
            tick();
        end
        out_ready = 1'b1;
        drive(2'b00, '0, 1'b0);
        tick();
        chk("skid_b_valid", 64'(out_valid), 64'd2);
        tick();
        chk("skid_done_occ", 64'(occ), 64'd0);
        chk("skid_sb_empty", 64'(sb.size()), 64'd0);

        // Flush with input in the same cycle
        out_ready = 1'b0;
        drive(2'b11, mk(16'h1111, 16'h1110), 1'b0);
        tick();
        drive(2'b11, mk(16'h2221, 16'h2220), 1'b0);
        tick();
        chk("flush_pre_occ", 64'(occ), 64'd2);
        flush = 1'b1;
        drive(2'b01, mk(16'h3331, 16'h3330), 1'b0);
        tick();
        flush = 1'b0;
        drive(2'b00, '0, 1'b0);
        chk("flush_occ", 64'(occ), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_data", 64'(out_data), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("flush_no_ghost", 64'(out_valid), 64'd0);

        // Partial kill of a held group
        out_ready = 1'b0;
        drive(2'b11, mk(16'h5551, 16'h5550), 1'b1);
        tick();
        drive(2'b00, '0, 1'b0);
        kill_mask = 2'b10;
        tick();
        kill_mask = 2'b00;
        chk("kill_part_valid", 64'(out_valid), 64'd1);
        chk("kill_part_lane0", 64'(out_data[W-1:0]), 64'h5550);
        g = sb.pop_front();
        g.v = 2'b01;
        sb.push_front(g);
        out_ready = 1'b1;
        tick();
        chk("kill_part_occ", 64'(occ), 64'd0);

        // Full kill in TWO while stalled: S promoted
        out_ready = 1'b0;
        x = mk(16'h7771, 16'h7770);
        y = mk(16'h8881, 16'h8880);
        drive(2'b11, x, 1'b1);
        tick();
        drive(2'b10, y, 1'b1);
        tick();
        drive(2'b00, '0, 1'b0);
        kill_mask = 2'b11;
        tick();
        kill_mask = 2'b00;
        void'(sb.pop_front());
        chk("kill_full_occ", 64'(occ), 64'd1);
        chk("kill_full_valid", 64'(out_valid), 64'd2);
        chk("kill_full_data", 64'(msk(out_valid, out_data)), 64'(msk(2'b10, y)));
        chk("kill_full_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("kill_full_drain", 64'(occ), 64'd0);

        // Full kill together with out_fire: kill ignored, M consumed
        out_ready = 1'b0;
        x = mk(16'h9991, 16'h9990);
        y = mk(16'haab1, 16'haab0);
        drive(2'b11, x, 1'b1);
        tick();
        drive(2'b01, y, 1'b1);
        tick();
        drive(2'b00, '0, 1'b0);
        kill_mask = 2'b11;
        out_ready = 1'b1;
        tick();
        kill_mask = 2'b00;
        chk("kill_fire_occ", 64'(occ), 64'd1);
        chk("kill_fire_valid", 64'(out_valid), 64'd1);
        chk("kill_fire_data", 64'(out_data[W-1:0]), 64'haab0);
        tick();
        chk("kill_fire_drain", 64'(occ), 64'd0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
